// File: rtl/clock_ctrl.sv
// -----------------------------------------------------------------------------
// clock_ctrl
//
// 24-hour time-of-day clock with a two-key setting interface.
//
// A prescaler divides clk down to a 1 s tick that advances hh:mm:ss while the
// block is in RUN. key_mode walks RUN -> SET_H -> SET_M -> SET_S -> RUN, and
// key_inc bumps the selected field (no carry into the next field). While a
// field is being set, its digit pair blinks through the blank_* outputs.
//
// Parameters
//   TICK_DIV  : clk cycles per 1 s tick (>= 2)
//   BLINK_DIV : clk cycles per blink half-period (>= 2)
//
// Ports
//   clk        in   system clock, all state changes on its rising edge
//   rst_n      in   asynchronous active-low reset
//   key_mode   in   one-cycle debounced pulse, advances the mode
//   key_inc    in   one-cycle debounced pulse, increments the selected field
//   hour       out  0..23, registered
//   minute     out  0..59, registered
//   second     out  0..59, registered
//   mode       out  0=RUN 1=SET_H 2=SET_M 3=SET_S, registered
//   blank_h/m/s out 1 = digit pair forced dark, registered
// -----------------------------------------------------------------------------
module clock_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] mode,
    output logic       blank_h,
    output logic       blank_m,
    output logic       blank_s
);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2,
        MODE_SET_S = 2'd3
    } mode_e;

    localparam int PW = (TICK_DIV  > 2) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_DIV - 1);
    localparam logic [BW-1:0] BLINK_ZERO = BW'(0);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MS_MAX   = 6'd59;

    // Increment with wrap to zero. Anything at or above the limit also
    // returns zero, so a field can never leave its legal range.
    function automatic logic [5:0] inc_wrap(input logic [5:0] val,
                                            input logic [5:0] max_val);
        if (val >= max_val) begin
            return 6'd0;
        end else begin
            return val + 6'd1;
        end
    endfunction

    // True when a field is at its last legal value and the next step carries.
    function automatic logic at_limit(input logic [5:0] val,
                                      input logic [5:0] max_val);
        return (val >= max_val);
    endfunction

    // Mode successor on key_mode.
    function automatic mode_e next_mode(input mode_e cur);
        case (cur)
            MODE_RUN:   return MODE_SET_H;
            MODE_SET_H: return MODE_SET_M;
            MODE_SET_M: return MODE_SET_S;
            MODE_SET_S: return MODE_RUN;
            default:    return MODE_RUN;
        endcase
    endfunction

    mode_e          mode_q,      mode_d;
    logic [5:0]     hour_q,      hour_d;
    logic [5:0]     minute_q,    minute_d;
    logic [5:0]     second_q,    second_d;
    logic [PW-1:0]  presc_q,     presc_d;
    logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
    logic           phase_q,     phase_d;
    logic           blank_h_q,   blank_h_d;
    logic           blank_m_q,   blank_m_d;
    logic           blank_s_q,   blank_s_d;

    logic           tick_s;
    logic           inc_accept_s;
    logic           blink_clear_s;

    // Tick and key qualification.
    always_comb begin
        tick_s        = 1'b0;
        inc_accept_s  = 1'b0;
        if (mode_q == MODE_RUN) begin
            tick_s = (presc_q == PRESC_MAX);
        end else begin
            tick_s = 1'b0;
        end
        // key_mode wins over a simultaneous key_inc; RUN ignores key_inc.
        if ((mode_q != MODE_RUN) && key_inc && !key_mode) begin
            inc_accept_s = 1'b1;
        end else begin
            inc_accept_s = 1'b0;
        end
    end

    // Next mode.
    always_comb begin
        mode_d = mode_q;
        if (key_mode) begin
            mode_d = next_mode(mode_q);
        end else begin
            mode_d = mode_q;
        end
    end

    // Next time value: carry chain on tick, single-field bump on key_inc.
    always_comb begin
        hour_d   = hour_q;
        minute_d = minute_q;
        second_d = second_q;
        if (tick_s) begin
            second_d = inc_wrap(second_q, MS_MAX);
            if (at_limit(second_q, MS_MAX)) begin
                minute_d = inc_wrap(minute_q, MS_MAX);
                if (at_limit(minute_q, MS_MAX)) begin
                    hour_d = inc_wrap(hour_q, HOUR_MAX);
                end else begin
                    hour_d = hour_q;
                end
            end else begin
                minute_d = minute_q;
            end
        end else if (inc_accept_s) begin
            case (mode_q)
                MODE_SET_H: hour_d   = inc_wrap(hour_q, HOUR_MAX);
                MODE_SET_M: minute_d = inc_wrap(minute_q, MS_MAX);
                MODE_SET_S: second_d = inc_wrap(second_q, MS_MAX);
                default: begin
                    hour_d   = hour_q;
                    minute_d = minute_q;
                    second_d = second_q;
                end
            endcase
        end else begin
            hour_d   = hour_q;
            minute_d = minute_q;
            second_d = second_q;
        end
    end

    // Prescaler. It only counts while RUN is both the current and the next
    // mode, so it already reads 0 on the edge that returns to RUN and the
    // first tick after that edge lands a full TICK_DIV cycles later.
    always_comb begin
        presc_d = PRESC_ZERO;
        if ((mode_q == MODE_RUN) && (mode_d == MODE_RUN)) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = PRESC_ZERO;
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end else begin
            presc_d = PRESC_ZERO;
        end
    end

    // Blink timer: restarts visible on any mode change or accepted increment,
    // idles at zero in RUN.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        phase_d       = phase_q;
        blink_clear_s = (mode_d == MODE_RUN) || (mode_d != mode_q) || inc_accept_s;
        if (blink_clear_s) begin
            blink_cnt_d = BLINK_ZERO;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = BLINK_ZERO;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_ONE;
            phase_d     = phase_q;
        end
    end

    // Blank outputs follow the next-state mode and phase so they switch on
    // the same edge as the state they describe.
    always_comb begin
        blank_h_d = 1'b0;
        blank_m_d = 1'b0;
        blank_s_d = 1'b0;
        case (mode_d)
            MODE_SET_H: blank_h_d = phase_d;
            MODE_SET_M: blank_m_d = phase_d;
            MODE_SET_S: blank_s_d = phase_d;
            default: begin
                blank_h_d = 1'b0;
                blank_m_d = 1'b0;
                blank_s_d = 1'b0;
            end
        endcase
    end

    // State register for the whole block; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_RUN;
            hour_q      <= 6'd0;
            minute_q    <= 6'd0;
            second_q    <= 6'd0;
            presc_q     <= PRESC_ZERO;
            blink_cnt_q <= BLINK_ZERO;
            phase_q     <= 1'b0;
            blank_h_q   <= 1'b0;
            blank_m_q   <= 1'b0;
            blank_s_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            hour_q      <= hour_d;
            minute_q    <= minute_d;
            second_q    <= second_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blank_h_q   <= blank_h_d;
            blank_m_q   <= blank_m_d;
            blank_s_q   <= blank_s_d;
        end
    end

    assign hour    = hour_q;
    assign minute  = minute_q;
    assign second  = second_q;
    assign mode    = mode_q;
    assign blank_h = blank_h_q;
    assign blank_m = blank_m_q;
    assign blank_s = blank_s_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_ctrl
//
// Scoreboard bench for clock_ctrl with TICK_DIV=4, BLINK_DIV=3. The driver
// applies keys, advances a reference model that keeps time as a count of
// seconds since midnight, and queues the expected outputs; the monitor pops
// and compares on every falling clock edge and on every asynchronous reset.
// -----------------------------------------------------------------------------
module tb_clock_ctrl;

    localparam int TICK  = 4;
    localparam int BLINK = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc  = 1'b0;
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] mode;
    logic       blank_h;
    logic       blank_m;
    logic       blank_s;

    typedef struct packed {
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] md;
        logic       bh;
        logic       bm;
        logic       bs;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model state
    int secs;       // seconds since midnight, 0..86399
    int mmode;      // 0..3
    int run_age;    // edges spent in RUN since entering it
    int blink_age;  // edges since the blink timer was last restarted

    clock_ctrl #(.TICK_DIV(TICK), .BLINK_DIV(BLINK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .hour     (hour),
        .minute   (minute),
        .second   (second),
        .mode     (mode),
        .blank_h  (blank_h),
        .blank_m  (blank_m),
        .blank_s  (blank_s)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic snap_t model_snap();
        snap_t r;
        int    ph;
        r.h  = 6'(secs / 3600);
        r.m  = 6'((secs / 60) % 60);
        r.s  = 6'(secs % 60);
        r.md = 2'(mmode);
        ph   = (mmode != 0) ? ((blink_age / BLINK) % 2) : 0;
        r.bh = (mmode == 1) && (ph == 1);
        r.bm = (mmode == 2) && (ph == 1);
        r.bs = (mmode == 3) && (ph == 1);
        return r;
    endfunction

    function automatic void model_reset();
        secs      = 0;
        mmode     = 0;
        run_age   = 0;
        blink_age = 0;
    endfunction

    function automatic void model_edge(bit km, bit ki);
        int h, m, s;
        if (mmode == 0) begin
            if ((run_age % TICK) == TICK - 1) secs = (secs + 1) % 86400;
            run_age++;
            if (km) begin
                mmode     = 1;
                blink_age = 0;
            end
        end else if (km) begin
            mmode     = (mmode + 1) % 4;
            blink_age = 0;
            run_age   = 0;
        end else if (ki) begin
            h = secs / 3600;
            m = (secs / 60) % 60;
            s = secs % 60;
            if (mmode == 1) h = (h + 1) % 24;
            if (mmode == 2) m = (m + 1) % 60;
            if (mmode == 3) s = (s + 1) % 60;
            secs      = h * 3600 + m * 60 + s;
            blink_age = 0;
        end else begin
            blink_age++;
        end
    endfunction

    // One clock cycle of stimulus; the expectation for the edge is queued.
    task automatic cycle(bit km, bit ki);
        key_mode = km;
        key_inc  = ki;
        @(posedge clk);
        if (rst_n) model_edge(km, ki);
        else       model_reset();
        exp_q.push_back(model_snap());
        #2;
        key_mode = 1'b0;
        key_inc  = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic incs(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
    endtask

    // Drop rst_n between edges; the outputs must clear before the next edge.
    task automatic async_reset();
        #6;
        model_reset();
        exp_q.push_back(model_snap());
        rst_n = 1'b0;
        idle(2);
        #5;
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        snap_t e;
        snap_t got;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{h: hour, m: minute, s: second, md: mode,
                        bh: blank_h, bm: blank_m, bs: blank_s};
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL snapshot #%0d t=%0t: got %0d:%0d:%0d mode=%0d blank=%b%b%b, want %0d:%0d:%0d mode=%0d blank=%b%b%b",
                             n_cmp, $time, got.h, got.m, got.s, got.md, got.bh, got.bm, got.bs,
                             e.h, e.m, e.s, e.md, e.bh, e.bm, e.bs);
                end
            end
        end
    end

    initial begin
        model_reset();

        // Reset held, then released; 12 cycles of RUN -> 00:00:03.
        idle(3);
        #5;
        rst_n = 1'b1;
        idle(12);

        // SET_H, 25 increments: hour wraps 23 -> 0 and ends at 1.
        cycle(1'b1, 1'b0);
        incs(25);
        // Preset 23:59:59 and return to RUN; 4 cycles later 00:00:00.
        incs(22);
        cycle(1'b1, 1'b0);
        incs(59);
        cycle(1'b1, 1'b0);
        incs(56);
        cycle(1'b1, 1'b0);
        idle(9);

        // In SET_M, key_mode and key_inc together: only the mode advances,
        // then blank_s runs 3 cycles visible, 3 dark.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        idle(8);
        cycle(1'b1, 1'b0);
        idle(6);

        // Tick coinciding with key_mode, then exit.
        idle(1);
        cycle(1'b1, 1'b0);
        idle(4);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        idle(5);

        // SET_H at hour 5, asynchronous reset between edges.
        cycle(1'b1, 1'b0);
        incs(5);
        idle(2);
        async_reset();
        idle(6);

        // Random key traffic with occasional asynchronous resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0);
            end
        end

        @(negedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
